// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: transfer sizes,
// controller states and the size-to-byte-count helper.
package mem_ctrl_pkg;

    // Access size encodings as presented on lsb_size
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        MST_IDLE  = 2'd0,
        MST_READ  = 2'd1,
        MST_WRITE = 2'd2
    } mst_state_e;

    // Number of bus byte cycles for an access; the unused encoding 3 is a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            MEM_SIZE_B: n = 3'd1;
            MEM_SIZE_H: n = 3'd2;
            default:    n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide external bus controller. Arbitrates instruction fetch against the
// load/store buffer, serialises 1/2/4-byte accesses into byte cycles and
// reassembles little-endian read data. Freezes on rdy=0, aborts reads on clear,
// and holds IO stores while the UART transmit buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_HI  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lsb_req,
    input  logic                  lsb_we,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [1:0]            lsb_size,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata
);

    mst_state_e            state, state_nxt;
    logic [2:0]            cnt;        // index of the address on the bus this cycle
    logic [2:0]            cnt_inc;
    logic [2:0]            cap_n;      // byte count of the captured request
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [31:0]           rbuf;       // bytes gathered so far
    logic [31:0]           asm_word;   // rbuf with this cycle's mem_din merged in
    logic [1:0]            byte_sel;
    logic                  src_lsb;
    logic                  prio_lsb;   // 1: LSB wins the next contention
    logic                  wr_q;
    logic                  gnt_if, gnt_lsb;
    logic                  rd_abort, rd_last;
    logic                  wr_stall, wr_last;

    function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
        return a[IO_SEL_HI] & a[IO_SEL_HI-1];
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

    // mem_din always answers the previous cycle's address, so byte cnt-1 arrives now
    assign cnt_inc  = cnt + 3'd1;
    assign byte_sel = cnt[1:0] - 2'd1;
    assign mem_wr   = wr_q & rdy & ~wr_stall;

    // Next-state, grant and per-state strobes
    always_comb begin
        state_nxt = state;
        gnt_if    = 1'b0;
        gnt_lsb   = 1'b0;
        rd_abort  = 1'b0;
        rd_last   = 1'b0;
        wr_stall  = 1'b0;
        wr_last   = 1'b0;
        asm_word  = rbuf;
        asm_word[8*byte_sel +: 8] = mem_din;
        case (state)
            MST_IDLE: begin
                if (!if_done && !lsb_done && !clear) begin
                    gnt_lsb = lsb_req & (~if_req | prio_lsb);
                    gnt_if  = if_req & (~lsb_req | ~prio_lsb);
                end
                if (gnt_lsb)
                    state_nxt = lsb_we ? MST_WRITE : MST_READ;
                else if (gnt_if)
                    state_nxt = MST_READ;
            end
            MST_READ: begin
                if (clear) begin
                    rd_abort  = 1'b1;
                    state_nxt = MST_IDLE;
                end else if (cnt == cap_n) begin
                    rd_last   = 1'b1;
                    state_nxt = MST_IDLE;
                end
            end
            MST_WRITE: begin
                wr_stall = is_io(mem_a) & io_buffer_full;
                if (!wr_stall && cnt == cap_n - 3'd1) begin
                    wr_last   = 1'b1;
                    state_nxt = MST_IDLE;
                end
            end
            default: state_nxt = MST_IDLE;
        endcase
    end

    // State register, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst)
            state <= MST_IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    // Bus drive, byte counter, read assembly and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_a     <= '0;
            mem_dout  <= '0;
            wr_q      <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
            prio_lsb  <= 1'b1;
            src_lsb   <= 1'b0;
            cnt       <= '0;
            cap_n     <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rbuf      <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                MST_IDLE: begin
                    if (gnt_if || gnt_lsb) begin
                        cnt       <= '0;
                        rbuf      <= '0;
                        src_lsb   <= gnt_lsb;
                        prio_lsb  <= gnt_if;
                        cap_addr  <= gnt_lsb ? lsb_addr : if_addr;
                        mem_a     <= gnt_lsb ? lsb_addr : if_addr;
                        cap_n     <= gnt_lsb ? size_bytes(lsb_size) : 3'd4;
                        cap_wdata <= lsb_wdata;
                        if (gnt_lsb && lsb_we) begin
                            wr_q     <= 1'b1;
                            mem_dout <= lsb_wdata[7:0];
                        end
                    end
                end
                MST_READ: begin
                    if (rd_abort) begin
                        mem_a <= '0;
                    end else if (rd_last) begin
                        mem_a <= '0;
                        if (src_lsb) begin
                            lsb_done  <= 1'b1;
                            lsb_rdata <= asm_word;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= asm_word;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt != 3'd0)
                            rbuf <= asm_word;
                        if (cnt_inc < cap_n)
                            mem_a <= cap_addr + ADDR_WIDTH'(cnt_inc);
                    end
                end
                MST_WRITE: begin
                    if (wr_last) begin
                        wr_q     <= 1'b0;
                        mem_a    <= '0;
                        mem_dout <= '0;
                        lsb_done <= 1'b1;
                    end else if (!wr_stall) begin
                        cnt      <= cnt_inc;
                        mem_a    <= cap_addr + ADDR_WIDTH'(cnt_inc);
                        mem_dout <= get_byte(cap_wdata, cnt_inc[1:0]);
                    end
                end
                default: begin
                    wr_q  <= 1'b0;
                    mem_a <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Owns the single byte-wide external memory/IO bus (mem_din/mem_dout/mem_a/mem_wr) of the RV32 core.
- Arbitrates between instruction fetch (IF) and the load/store buffer (LSB).
- Sequences each 1/2/4-byte access as consecutive byte cycles and reassembles little-endian words.
- Sits between the cpu top-level bus pins and the IF/LSB units; honours rdy pause, ROB clear and UART back-pressure.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_SEL_HI, 17, upper bit of IO decode field; an address is IO when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rdy  in  1  global ready; low = freeze
- clear  in  1  ROB mispredict clear
- mem_din  in  8  read byte; reflects the address driven in the previous active cycle
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART tx buffer full
- if_req  in  1  fetch request; level, held until if_done
- if_addr  in  32  fetch address (always 4 bytes)
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word
- lsb_req  in  1  LSB request; level, held until lsb_done
- lsb_we  in  1  1 = store
- lsb_addr  in  32  access address
- lsb_size  in  2  0 = byte, 1 = half, 2 = word
- lsb_wdata  in  32  store data; byte i = wdata[8i+7:8i]
- lsb_done  out  1  one-cycle pulse
- lsb_rdata  out  32  load data, zero-extended raw bytes

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, round-robin pointer = LSB.
- rdy=0: all state, counters and outputs frozen, except mem_wr, which is forced to 0. No capture occurs. On resume the held mem_a is re-presented, so mem_din stays consistent.
- States:
  - IDLE: mem_wr=0, mem_a=0, mem_dout=0.
  - READ, WRITE: 3-bit byte counter i and captured request (source, addr, size, wdata).
- Grant in IDLE:
  - Not granted when a done pulse is high this cycle or clear=1.
  - Single requester: granted.
  - Both requesting: grant the side not granted last (round robin); first contention after reset goes to LSB.
- READ timing, n bytes, grant at edge E0:
  - mem_a = addr+i in cycles 1..n.
  - mem_din captured into byte i at the edges ending cycles 2..n+1.
  - done pulse and data registered high in cycle n+2; state returns to IDLE in that cycle.
  - Word fetch: done at cycle 6.
- WRITE timing:
  - mem_a = addr+i, mem_dout = byte i, mem_wr=1 in cycles 1..n.
  - lsb_done high in cycle n+1.
- Address increments by 1 per byte with full 32-bit wrap and no alignment requirement.
- IO stall: in WRITE, if the address is IO and io_buffer_full=1 that cycle, then mem_wr=0 and i does not advance. Retry every cycle.
- clear=1 (with rdy=1):
  - In READ (IF or LSB): abort, go to IDLE next cycle, no done pulse, captured data discarded.
  - In WRITE: ignored; the store completes and lsb_done pulses normally (stores only issue post-commit).
- Requesters must drop req in or before the cycle after their done. A req still high in the cycle after done starts a new transfer.
- if_done and lsb_done are never high simultaneously.
- lsb_size=3 is illegal; treat as word.

Decomposition:
- config.v gains: `MEM_SIZE_B/H/W` size encodings, `MST_IDLE/READ/WRITE` state encodings, and an IO-region test macro.
- Single flat module; byte counter and assembler inline. No sub-module.

Test Plan:
- IF read 0x100, memory holds 13 05 00 00 -> mem_a 0x100..0x103 in cycles 1-4; if_done with if_data=0x00000513 in cycle 6.
- LSB store half 0xBEEF at 0x1002 -> (0x1002, 0xEF, wr=1) then (0x1003, 0xBE, wr=1); lsb_done in cycle 3.
- if_req and lsb_req both high continuously -> grants alternate LSB, IF, LSB starting from reset; never two done pulses together.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 for 3 cycles, then a single write of 0x41; lsb_done 1 cycle later.
- clear in cycle 3 of an IF word read -> IDLE in cycle 4, no if_done; a pending lsb_req is granted in cycle 4 or later.
- rdy low for 2 cycles during cycle 2 of an LSB word load -> mem_a held, mem_wr=0, no capture; lsb_rdata correct; lsb_done delayed by exactly 2 cycles.
